// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes one MIPS instruction into ALU operands/control,
// applies EX/MEM and MEM/WB forwarding, and inserts bubbles on flush and load-use hazards.
module id_ex_stage #(
    parameter logic [5:0] NOP_CTRL = 6'b111111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        ex_mem_wr,
    input  logic [4:0]  ex_mem_rd,
    input  logic [31:0] ex_mem_result,
    input  logic        mem_wb_wr,
    input  logic [4:0]  mem_wb_rd,
    input  logic [31:0] mem_wb_data,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [5:0]  alu_control,
    output logic        out_valid,
    output logic [4:0]  dest_reg,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] store_data,
    output logic        load_use_stall
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  ctrl;
        logic        vld;
        logic [4:0]  dest;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] sd;
    } stage_t;

    function automatic stage_t bubble();
        stage_t s;
        s      = '0;
        s.ctrl = NOP_CTRL;
        return s;
    endfunction

    // $0 is hardwired zero; the younger EX/MEM result wins over MEM/WB.
    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf_data);
        if (src == 5'd0)                         return 32'd0;
        else if (ex_mem_wr && ex_mem_rd == src) return ex_mem_result;
        else if (mem_wb_wr && mem_wb_rd == src) return mem_wb_data;
        else                                     return rf_data;
    endfunction

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sx, imm_zx, fwd_rs, fwd_rt;
    logic        uses_rt;
    stage_t      dec, stage_q, stage_d;

    assign op     = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign imm_sx = {{16{instr[15]}}, instr[15:0]};
    assign imm_zx = {16'd0, instr[15:0]};
    assign fwd_rs = fwd(rs, rs_data);
    assign fwd_rt = fwd(rt, rt_data);

    always_comb begin
        dec      = '0;
        dec.vld  = 1'b1;
        dec.a    = fwd_rs;
        dec.b    = fwd_rt;
        dec.sd   = fwd_rt;
        dec.dest = rt;
        dec.ctrl = NOP_CTRL;
        uses_rt  = 1'b0;
        case (op)
            OP_RTYPE: begin dec.ctrl = instr[5:0]; dec.dest = rd; dec.rw = 1'b1; uses_rt = 1'b1; end
            OP_ADDIU: begin dec.ctrl = 6'b100001; dec.b = imm_sx; dec.rw = 1'b1; end
            OP_ANDI:  begin dec.ctrl = 6'b100100; dec.b = imm_zx; dec.rw = 1'b1; end
            OP_ORI:   begin dec.ctrl = 6'b100101; dec.b = imm_zx; dec.rw = 1'b1; end
            OP_SLTIU: begin dec.ctrl = 6'b101011; dec.b = imm_sx; dec.rw = 1'b1; end
            OP_LW:    begin dec.ctrl = 6'b100001; dec.b = imm_sx; dec.rw = 1'b1; dec.mr = 1'b1; end
            OP_SW:    begin dec.ctrl = 6'b100001; dec.b = imm_sx; dec.mw = 1'b1; uses_rt = 1'b1; end
            OP_BEQ:   begin dec.ctrl = 6'b100011; uses_rt = 1'b1; end
            default: begin
                // Unknown op still flows as a valid slot, but with no operands or side effects.
                dec.a    = 32'd0;
                dec.b    = 32'd0;
                dec.sd   = 32'd0;
                dec.dest = 5'd0;
            end
        endcase
    end

    assign load_use_stall = in_valid & stage_q.vld & stage_q.mr & (stage_q.dest != 5'd0) &
                            ((stage_q.dest == rs) | ((stage_q.dest == rt) & uses_rt));

    always_comb begin
        stage_d = stage_q;
        if (flush)
            stage_d = bubble();
        else if (stall)
            stage_d = stage_q;
        else if (load_use_stall || !in_valid)
            stage_d = bubble();
        else
            stage_d = dec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_q <= bubble();
        else     stage_q <= stage_d;
    end

    assign a           = stage_q.a;
    assign b           = stage_q.b;
    assign alu_control = stage_q.ctrl;
    assign out_valid   = stage_q.vld;
    assign dest_reg    = stage_q.dest;
    assign reg_write   = stage_q.rw;
    assign mem_read    = stage_q.mr;
    assign mem_write   = stage_q.mw;
    assign store_data  = stage_q.sd;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboarded bench for id_ex_stage: directed test-plan cases followed by random traffic
// checked against an instruction-level reference model.
module tb_id_ex_stage;
    logic        clk, rst, in_valid, stall, flush, ex_mem_wr, mem_wb_wr;
    logic [31:0] instr, rs_data, rt_data, ex_mem_result, mem_wb_data;
    logic [4:0]  ex_mem_rd, mem_wb_rd;
    logic [31:0] a, b, store_data;
    logic [5:0]  alu_control;
    logic        out_valid, reg_write, mem_read, mem_write, load_use_stall;
    logic [4:0]  dest_reg;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .flush(flush),
        .ex_mem_wr(ex_mem_wr), .ex_mem_rd(ex_mem_rd), .ex_mem_result(ex_mem_result),
        .mem_wb_wr(mem_wb_wr), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
        .a(a), .b(b), .alu_control(alu_control), .out_valid(out_valid),
        .dest_reg(dest_reg), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .store_data(store_data), .load_use_stall(load_use_stall)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  ctrl;
        logic        vld;
        logic [4:0]  dest;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] sd;
    } exp_t;

    typedef struct packed {
        exp_t e;
        logic lus;
    } sb_t;

    typedef struct {
        logic        rst, inv, stall, flush, exw, mww;
        logic [31:0] instr, rsd, rtd, exres, mwd;
        logic [4:0]  exrd, mwrd;
    } stim_t;

    sb_t  q[$];
    exp_t st;
    int   errors = 0;
    int   checks = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t bubble();
        exp_t e;
        e      = '0;
        e.ctrl = 6'h3F;
        return e;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic logic [31:0] mfwd(input logic [4:0] r, input logic [31:0] rf, input stim_t s);
        if (r == 0) return 32'd0;
        if (s.exw && s.exrd == r) return s.exres;
        if (s.mww && s.mwrd == r) return s.mwd;
        return rf;
    endfunction

    // What the ALU should see for this instruction, straight from the opcode table.
    function automatic exp_t mdecode(input stim_t s);
        exp_t        e;
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        logic [31:0] sx, zx;
        op   = s.instr[31:26];
        rs   = s.instr[25:21];
        rt   = s.instr[20:16];
        sx   = {{16{s.instr[15]}}, s.instr[15:0]};
        zx   = {16'd0, s.instr[15:0]};
        e    = '0;
        e.vld  = 1;
        e.a    = mfwd(rs, s.rsd, s);
        e.b    = mfwd(rt, s.rtd, s);
        e.sd   = e.b;
        e.dest = rt;
        case (op)
            6'h00: begin e.ctrl = s.instr[5:0]; e.dest = s.instr[15:11]; e.rw = 1; end
            6'h09: begin e.ctrl = 6'h21; e.b = sx; e.rw = 1; end
            6'h0C: begin e.ctrl = 6'h24; e.b = zx; e.rw = 1; end
            6'h0D: begin e.ctrl = 6'h25; e.b = zx; e.rw = 1; end
            6'h0B: begin e.ctrl = 6'h2B; e.b = sx; e.rw = 1; end
            6'h23: begin e.ctrl = 6'h21; e.b = sx; e.rw = 1; e.mr = 1; end
            6'h2B: begin e.ctrl = 6'h21; e.b = sx; e.mw = 1; end
            6'h04: begin e.ctrl = 6'h23; end
            default: begin e.ctrl = 6'h3F; e.a = 0; e.b = 0; e.sd = 0; e.dest = 0; end
        endcase
        return e;
    endfunction

    function automatic logic mlus(input exp_t cur, input stim_t s);
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic       reads_rt;
        op       = s.instr[31:26];
        rs       = s.instr[25:21];
        rt       = s.instr[20:16];
        reads_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        return s.inv && cur.vld && cur.mr && cur.dest != 0 &&
               (cur.dest == rs || (cur.dest == rt && reads_rt));
    endfunction

    // Apply one cycle of stimulus at the falling edge; queue what the DUT must show now.
    task automatic drive(input stim_t s);
        sb_t  ent;
        logic lus;
        @(negedge clk);
        rst = s.rst; in_valid = s.inv; instr = s.instr; rs_data = s.rsd; rt_data = s.rtd;
        stall = s.stall; flush = s.flush;
        ex_mem_wr = s.exw; ex_mem_rd = s.exrd; ex_mem_result = s.exres;
        mem_wb_wr = s.mww; mem_wb_rd = s.mwrd; mem_wb_data = s.mwd;
        if (s.rst) st = bubble();
        lus     = mlus(st, s);
        ent.e   = st;
        ent.lus = lus;
        q.push_back(ent);
        if (s.rst || s.flush) st = bubble();
        else if (s.stall)     st = st;
        else if (lus || !s.inv) st = bubble();
        else                  st = mdecode(s);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every falling edge with a queued expectation, compare the whole output set.
    initial begin
        sb_t  c;
        exp_t act;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                c   = q.pop_front();
                act = {a, b, alu_control, out_valid, dest_reg, reg_write, mem_read, mem_write, store_data};
                checks++;
                if (act !== c.e) begin
                    errors++;
                    $display("FAIL sb_regs: got %h expected %h", act, c.e);
                end
                checks++;
                if (load_use_stall !== c.lus) begin
                    errors++;
                    $display("FAIL sb_lus: got %b expected %b", load_use_stall, c.lus);
                end
            end
        end
    end

    function automatic stim_t rand_stim();
        stim_t      s;
        logic [5:0] ops [8];
        int         k;
        ops = '{6'h00, 6'h09, 6'h0C, 6'h0D, 6'h0B, 6'h23, 6'h2B, 6'h04};
        s = idle();
        k = $urandom_range(0, 9);
        s.instr = {(k < 8) ? ops[k] : 6'($urandom), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 16'($urandom)};
        s.rst   = ($urandom_range(0, 99) < 2);
        s.inv   = ($urandom_range(0, 99) < 80);
        s.stall = ($urandom_range(0, 99) < 15);
        s.flush = ($urandom_range(0, 99) < 6);
        s.rsd   = $urandom; s.rtd = $urandom;
        s.exw   = 1'($urandom); s.exrd = 5'($urandom_range(0, 7)); s.exres = $urandom;
        s.mww   = 1'($urandom); s.mwrd = 5'($urandom_range(0, 7)); s.mwd   = $urandom;
        return s;
    endfunction

    initial begin
        stim_t s;
        rst = 1; in_valid = 0; instr = 0; rs_data = 0; rt_data = 0; stall = 0; flush = 0;
        ex_mem_wr = 0; ex_mem_rd = 0; ex_mem_result = 0;
        mem_wb_wr = 0; mem_wb_rd = 0; mem_wb_data = 0;
        st = bubble();

        s = idle(); s.rst = 1; drive(s); drive(s);

        // addu $3,$1,$2
        s = idle(); s.inv = 1; s.instr = 32'h00221821; s.rsd = 5; s.rtd = 7; drive(s);
        after_edge();
        chk("addu_a", a, 5); chk("addu_b", b, 7); chk("addu_ctrl", 32'(alu_control), 32'h21);
        chk("addu_dest", 32'(dest_reg), 3); chk("addu_rw", 32'(reg_write), 1);

        // async reset with loaded outputs, checked before any clock edge
        s = idle(); s.rst = 1; drive(s); #1;
        chk("rst_a", a, 0); chk("rst_ctrl", 32'(alu_control), 32'h3F); chk("rst_vld", 32'(out_valid), 0);
        s = idle(); drive(s);

        s = idle(); s.inv = 1; s.instr = 32'h3424FFFF; s.rsd = 1; drive(s);
        after_edge(); chk("ori_b", b, 32'h0000FFFF); chk("ori_ctrl", 32'(alu_control), 32'h25);
        s.instr = 32'h2424FFFF; drive(s);
        after_edge(); chk("addiu_b", b, 32'hFFFFFFFF);

        s = idle(); s.inv = 1; s.instr = 32'h00221821; s.rsd = 5; s.rtd = 7;
        s.exw = 1; s.exrd = 1; s.exres = 10; s.mww = 1; s.mwrd = 1; s.mwd = 20; drive(s);
        after_edge(); chk("fwd_exmem_prio", a, 10);
        s = idle(); s.inv = 1; s.instr = 32'h00221821; s.rsd = 5; s.rtd = 7;
        s.mww = 1; s.mwrd = 2; s.mwd = 30; drive(s);
        after_edge(); chk("fwd_memwb_b", b, 30);
        s = idle(); s.inv = 1; s.instr = 32'h00021821; s.rsd = 9; s.rtd = 7;
        s.exw = 1; s.exrd = 0; s.exres = 55; s.mww = 1; s.mwrd = 0; s.mwd = 66; drive(s);
        after_edge(); chk("fwd_r0", a, 0);

        // lw $5,0($1) then subu $6,$5,$2
        s = idle(); s.inv = 1; s.instr = 32'h8C250000; s.rsd = 100; drive(s);
        s = idle(); s.inv = 1; s.instr = 32'h00A23023; s.rsd = 1; s.rtd = 2; drive(s);
        #1; chk("lu_stall", 32'(load_use_stall), 1);
        after_edge(); chk("lu_bubble_vld", 32'(out_valid), 0); chk("lu_bubble_ctrl", 32'(alu_control), 32'h3F);
        s.mww = 1; s.mwrd = 5; s.mwd = 32'h1234; drive(s);
        #1; chk("lu_release", 32'(load_use_stall), 0);
        after_edge(); chk("lu_subu_ctrl", 32'(alu_control), 32'h23); chk("lu_subu_a", a, 32'h1234);

        s = idle(); s.inv = 1; s.instr = 32'h00221821; s.rsd = 5; s.rtd = 7; drive(s);
        for (int i = 0; i < 3; i++) begin
            s = rand_stim(); s.rst = 0; s.flush = 0; s.stall = 1; drive(s);
            after_edge(); chk("stall_a", a, 5); chk("stall_vld", 32'(out_valid), 1);
        end
        s.flush = 1; drive(s);
        after_edge(); chk("flush_vld", 32'(out_valid), 0); chk("flush_ctrl", 32'(alu_control), 32'h3F);

        for (int i = 0; i < 600; i++) drive(rand_stim());

        s = idle(); drive(s);
        repeat (2) @(negedge clk);
        #2;
        chk("sb_drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
